mux_arb_n: RTL
==============

MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL take parameter WIDTH, default 16: data width of every channel.
REQ-002 SHALL take parameter N, default 4: number of input channels (2..16).
REQ-003 SHALL take parameter SELW, default $clog2(N): width of the select and channel-index fields.
REQ-004 SHALL have port clk  input  1  sole clock; all logic updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mode  input  1  0 = direct select, 1 = round-robin arbitration.
REQ-007 SHALL have port sel  input  SELW  channel index used in direct mode.
REQ-008 SHALL have port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid  input  N  per-channel data-valid.
REQ-010 SHALL have port in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-012 SHALL have port out_valid  output  1  out_data holds an untaken word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 SHALL have port out_chan  output  SELW  index of the channel that supplied out_data.

Function
REQ-015 SHALL define slot_free = !out_valid || out_ready; loading is allowed only when slot_free.
REQ-016 Direct mode SHALL grant channel sel iff sel < N and in_valid[sel]; otherwise no grant.
REQ-017 Round-robin mode SHALL grant the first channel with in_valid set, searching from last_grant+1 upward, wrapping modulo N.
REQ-018 in_ready[g] SHALL be high (combinationally) iff channel g is granted and slot_free; all other bits low.
REQ-019 A transfer on channel g SHALL occur when in_valid[g] && in_ready[g]; on that edge out_data <= word g, out_chan <= g, out_valid <= 1.
REQ-020 Latency SHALL be exactly 1 cycle from transfer to out_valid; sustained throughput 1 word per cycle with out_ready held high.
REQ-021 When out_ready is high and no transfer occurs, out_valid SHALL clear on the next edge; out_data and out_chan hold their last values.
REQ-022 While out_valid && !out_ready, out_data, out_chan and out_valid SHALL be held stable and in_ready SHALL be all zero.
REQ-023 last_grant SHALL update to g only on a transfer in round-robin mode; direct-mode transfers SHALL NOT change it.
REQ-024 A change of mode or sel SHALL affect only the arbitration of the same cycle; a word already in the output register is unaffected.
REQ-025 With no in_valid bits set, no grant SHALL be issued and last_grant SHALL hold.
REQ-026 Simultaneous drain and load (out_ready high, transfer occurring) SHALL replace out_data with the new word and keep out_valid high.

Reset
REQ-027 On a clock edge with rst high: out_valid <= 0, out_data <= 0, out_chan <= 0, last_grant <= N-1 (so the first round-robin search starts at channel 0).
REQ-028 in_ready SHALL be all zero during any cycle in which rst is high; reset asserted mid-stream SHALL discard any held word.

Verification
REQ-029 Direct mode, WIDTH=16, N=4: sel=2, all valid, ch2=16'h5AF0, out_ready=1 -> in_ready=4'b0100, next cycle out_data=16'h5AF0, out_chan=2, out_valid=1.
REQ-030 Round-robin after reset with all four channels valid and out_ready=1 for 5 cycles -> out_chan sequence 0,1,2,3,0, one word per cycle.
REQ-031 Backpressure: out_valid=1, out_ready=0 for 3 cycles with new inputs changing -> out_data/out_chan unchanged, in_ready=4'b0000; on out_ready=1 the next grant loads in the same cycle.
REQ-032 Round-robin with only ch1 and ch3 valid, last_grant=1 -> grant ch3, then ch1, alternating.
REQ-033 Boundary: in_data all 16'h0000 then all 16'hFFFF, and sel=3 with in_valid[3]=0 -> no grant, out_valid clears after drain; pattern words pass bit-exact.
REQ-034 Reset mid-operation: rst=1 while out_valid=1 and out_ready=0 -> next edge out_valid=0, out_data=0, out_chan=0; first round-robin grant afterwards is ch0.

Source files
------------

// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
// mux_arb_n : N-channel registered mux, direct select or round-robin arbiter
// Revision  : 1.0
// ============================================================================
module mux_arb_n #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  localparam logic [SELW-1:0] c_LAST_RST = SELW'(N - 1);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_chan;
  logic [SELW-1:0]  r_last_grant;

  logic             w_slot_free;
  logic             w_dir_vld;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_word;
  logic [N-1:0]     w_ready;

  assign w_slot_free = !r_out_valid || out_ready;

  // Direct grant: sel must name an existing channel that is presenting data.
  always_comb begin
    w_dir_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i && in_valid[i]) w_dir_vld = 1'b1;
    end
  end

  // Round-robin search starts just after the last round-robin winner.
  always_comb begin
    int idx;
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_last_grant) + k) % N;
      if (!w_rr_vld && in_valid[idx]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = idx[SELW-1:0];
      end
    end
  end

  assign w_gnt_vld = mode ? w_rr_vld : w_dir_vld;
  assign w_gnt_idx = mode ? w_rr_idx : sel;
  assign w_xfer    = w_gnt_vld && w_slot_free && !rst;

  always_comb begin
    w_word  = '0;
    w_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(w_gnt_idx) == i) begin
        w_word     = in_data[i*WIDTH +: WIDTH];
        w_ready[i] = w_xfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_chan   <= '0;
      r_last_grant <= c_LAST_RST;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_chan  <= w_gnt_idx;
      if (mode) r_last_grant <= w_gnt_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;

endmodule
`default_nettype wire
